// File: rtl/decode_stage_hz_if.sv
// Signal bundle between IF/ID, writeback, execute and the decode stage.
// The slave modport is the decode stage; the master modport is whoever drives it.
interface decode_stage_hz_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);

    logic            if_valid;
    logic [31:0]     if_ir;
    logic [XLEN-1:0] if_pc;
    logic            wb_we;
    logic [RW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_flush;
    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_imm;
    logic [RW-1:0]   ex_rd;
    logic [RW-1:0]   ex_rs1;
    logic [RW-1:0]   ex_rs2;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_alusrc_imm;
    logic [1:0]      ex_wb_sel;
    logic            ex_illegal;

    modport master (
        output if_valid, if_ir, if_pc, wb_we, wb_rd, wb_data, ex_flush,
        input  stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rd, ex_rs1, ex_rs2,
               ex_funct3, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite,
               ex_branch, ex_jump, ex_alusrc_imm, ex_wb_sel, ex_illegal
    );

    modport slave (
        input  if_valid, if_ir, if_pc, wb_we, wb_rd, wb_data, ex_flush,
        output stall, ex_valid, ex_pc, ex_a, ex_b, ex_imm, ex_rd, ex_rs1, ex_rs2,
               ex_funct3, ex_funct7b5, ex_regwrite, ex_memread, ex_memwrite,
               ex_branch, ex_jump, ex_alusrc_imm, ex_wb_sel, ex_illegal
    );
endinterface

// File: rtl/decode_stage_hz.sv
// RV32I decode stage: register file with write-through bypass, control decode,
// load-use stall/bubble, flush, and the ID/EX pipeline register.
module decode_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic              clk,
    input logic              rst,
    decode_stage_hz_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   rd;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic            alusrcImm;
        logic [1:0]      wbSel;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0]    regs_q [NREGS];
    idex_t              ex_q;
    idex_t              ex_d;
    idex_t              dec;
    logic [31:0]        ir;
    logic [6:0]         opcode;
    logic [RW-1:0]      rs1Idx;
    logic [RW-1:0]      rs2Idx;
    logic [XLEN-1:0]    rs1Val;
    logic [XLEN-1:0]    rs2Val;
    logic signed [31:0] immI, immS, immB, immU, immJ, imm32;
    logic               rs1Used;
    logic               rs2Used;
    logic               hazard;
    logic               stallInt;

    assign ir     = bus.if_ir;
    assign opcode = ir[6:0];
    assign rs1Idx = RW'(ir[19:15]);
    assign rs2Idx = RW'(ir[24:20]);

    assign immI = {{20{ir[31]}}, ir[31:20]};
    assign immS = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign immB = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign immU = {ir[31:12], 12'b0};
    assign immJ = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // A writeback to the register being read this cycle is forwarded straight through.
    assign rs1Val = (rs1Idx == '0) ? '0 :
                    (bus.wb_we && bus.wb_rd == rs1Idx) ? bus.wb_data : regs_q[rs1Idx];
    assign rs2Val = (rs2Idx == '0) ? '0 :
                    (bus.wb_we && bus.wb_rd == rs2Idx) ? bus.wb_data : regs_q[rs2Idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (bus.wb_we && bus.wb_rd != '0) begin
            regs_q[bus.wb_rd] <= bus.wb_data;
        end
    end

    always_comb begin
        dec          = '0;
        imm32        = '0;
        rs1Used      = 1'b0;
        rs2Used      = 1'b0;
        dec.valid    = bus.if_valid;
        dec.pc       = bus.if_pc;
        dec.a        = rs1Val;
        dec.b        = rs2Val;
        dec.rd       = RW'(ir[11:7]);
        dec.rs1      = rs1Idx;
        dec.rs2      = rs2Idx;
        dec.funct3   = ir[14:12];
        dec.funct7b5 = ir[30];
        case (opcode)
            OP_R:      begin dec.regwrite = 1'b1; rs1Used = 1'b1; rs2Used = 1'b1; end
            OP_IALU:   begin dec.regwrite = 1'b1; dec.alusrcImm = 1'b1; rs1Used = 1'b1; imm32 = immI; end
            OP_LOAD:   begin dec.regwrite = 1'b1; dec.memread = 1'b1; dec.alusrcImm = 1'b1;
                             dec.wbSel = 2'd1; rs1Used = 1'b1; imm32 = immI; end
            OP_STORE:  begin dec.memwrite = 1'b1; dec.alusrcImm = 1'b1; rs1Used = 1'b1;
                             rs2Used = 1'b1; imm32 = immS; end
            OP_BRANCH: begin dec.branch = 1'b1; rs1Used = 1'b1; rs2Used = 1'b1; imm32 = immB; end
            OP_JAL:    begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.wbSel = 2'd2; imm32 = immJ; end
            OP_JALR:   begin dec.jump = 1'b1; dec.regwrite = 1'b1; dec.alusrcImm = 1'b1;
                             dec.wbSel = 2'd2; rs1Used = 1'b1; imm32 = immI; end
            OP_LUI, OP_AUIPC: begin dec.regwrite = 1'b1; dec.alusrcImm = 1'b1; imm32 = immU; end
            default:   dec.illegal = 1'b1;
        endcase
        dec.imm = XLEN'(imm32);
        // An empty IF/ID slot carries its data through but must never act.
        if (!bus.if_valid) begin
            dec.regwrite  = 1'b0;
            dec.memread   = 1'b0;
            dec.memwrite  = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.alusrcImm = 1'b0;
            dec.wbSel     = 2'd0;
            dec.illegal   = 1'b0;
        end
    end

    assign hazard   = ex_q.valid && ex_q.memread && ex_q.rd != '0 &&
                      ((rs1Used && ex_q.rd == rs1Idx) || (rs2Used && ex_q.rd == rs2Idx));
    assign stallInt = !bus.ex_flush && bus.if_valid && hazard;

    always_comb begin
        ex_d = dec;
        if (bus.ex_flush || stallInt) ex_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ex_q <= '0;
        else     ex_q <= ex_d;
    end

    assign bus.stall         = stallInt;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_a          = ex_q.a;
    assign bus.ex_b          = ex_q.b;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_rs1        = ex_q.rs1;
    assign bus.ex_rs2        = ex_q.rs2;
    assign bus.ex_funct3     = ex_q.funct3;
    assign bus.ex_funct7b5   = ex_q.funct7b5;
    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_memread    = ex_q.memread;
    assign bus.ex_memwrite   = ex_q.memwrite;
    assign bus.ex_branch     = ex_q.branch;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_alusrc_imm = ex_q.alusrcImm;
    assign bus.ex_wb_sel     = ex_q.wbSel;
    assign bus.ex_illegal    = ex_q.illegal;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed and randomised checks of decode_stage_hz against a cycle-level
// reference model of the register file, decode rules and hazard behaviour.
module tb_decode_stage_hz;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_stage_hz_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();
    decode_stage_hz #(.XLEN(XLEN), .NREGS(NREGS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       valid, regwrite, memread, memwrite, branch, jump, alusrc;
        logic [1:0] wbSel;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc, a, b, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  funct3;
        logic        funct7b5;
    } data_t;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mReg [32];
    ctrl_t       mCtrl;
    data_t       mData;

    function automatic ctrl_t dutCtrl();
        return {bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_branch,
                bus.ex_jump, bus.ex_alusrc_imm, bus.ex_wb_sel, bus.ex_illegal};
    endfunction

    function automatic data_t dutData();
        return {bus.ex_pc, bus.ex_a, bus.ex_b, bus.ex_imm, bus.ex_rd, bus.ex_rs1, bus.ex_rs2,
                bus.ex_funct3, bus.ex_funct7b5};
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = '0;
        mCtrl = '0;
        mData = '0;
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (bus.wb_we && bus.wb_rd == idx) return bus.wb_data;
        return mReg[idx];
    endfunction

    // Decode rules table; immediates built by arithmetic shifts and masks.
    function automatic void modelDecode(input logic [31:0] ir, input logic v, output ctrl_t c,
                                        output logic u1, output logic u2, output logic [31:0] imm);
        logic signed [31:0] sir;
        logic [31:0] sh20, sh19, sh11;
        sir  = ir;
        sh20 = sir >>> 20;
        sh19 = sir >>> 19;
        sh11 = sir >>> 11;
        c = '0; u1 = 1'b0; u2 = 1'b0; imm = '0;
        case (ir[6:0])
            7'h33: begin c.regwrite = 1; u1 = 1; u2 = 1; end
            7'h13: begin c.regwrite = 1; c.alusrc = 1; u1 = 1; imm = sh20; end
            7'h03: begin c.regwrite = 1; c.memread = 1; c.alusrc = 1; c.wbSel = 1; u1 = 1; imm = sh20; end
            7'h23: begin c.memwrite = 1; c.alusrc = 1; u1 = 1; u2 = 1;
                         imm = (sh20 & 32'hFFFF_FFE0) | 32'(ir[11:7]); end
            7'h63: begin c.branch = 1; u1 = 1; u2 = 1;
                         imm = (sh19 & 32'hFFFF_F000) | (32'(ir[7]) << 11) |
                               (32'(ir[30:25]) << 5) | (32'(ir[11:8]) << 1); end
            7'h6F: begin c.jump = 1; c.regwrite = 1; c.wbSel = 2;
                         imm = (sh11 & 32'hFFF0_0000) | (ir & 32'h000F_F000) |
                               (32'(ir[20]) << 11) | (32'(ir[30:21]) << 1); end
            7'h67: begin c.jump = 1; c.regwrite = 1; c.alusrc = 1; c.wbSel = 2; u1 = 1; imm = sh20; end
            7'h37, 7'h17: begin c.regwrite = 1; c.alusrc = 1; imm = ir & 32'hFFFF_F000; end
            default: c.illegal = 1;
        endcase
        c.valid = 1'b1;
        if (!v) c = '0;
    endfunction

    function automatic logic modelStall();
        ctrl_t c; logic u1, u2; logic [31:0] imm;
        modelDecode(bus.if_ir, 1'b1, c, u1, u2, imm);
        return !bus.ex_flush && bus.if_valid && mCtrl.valid && mCtrl.memread && mData.rd != 0 &&
               ((u1 && mData.rd == bus.if_ir[19:15]) || (u2 && mData.rd == bus.if_ir[24:20]));
    endfunction

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd, input logic flush);
        bus.if_valid = v; bus.if_ir = ir; bus.if_pc = pc;
        bus.wb_we = we; bus.wb_rd = rd; bus.wb_data = wd; bus.ex_flush = flush;
    endtask

    // Advance one clock edge, updating the model with the inputs present at that edge.
    task automatic tick();
        ctrl_t c; data_t d; logic u1, u2, st;
        st = modelStall();
        modelDecode(bus.if_ir, bus.if_valid, c, u1, u2, d.imm);
        d.pc = bus.if_pc; d.rd = bus.if_ir[11:7]; d.rs1 = bus.if_ir[19:15]; d.rs2 = bus.if_ir[24:20];
        d.funct3 = bus.if_ir[14:12]; d.funct7b5 = bus.if_ir[30];
        d.a = mRead(d.rs1); d.b = mRead(d.rs2);
        @(posedge clk);
        if (bus.ex_flush || st) begin c = '0; d = '0; end
        if (bus.wb_we && bus.wb_rd != 0) mReg[bus.wb_rd] = bus.wb_data;
        mCtrl = c; mData = d;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        modelReset();
        #1;
        checks++; if (dutCtrl() !== ctrl_t'(0)) begin errors++; $display("[TB] FAIL reset_ctrl got=%h exp=0", dutCtrl()); end
        checks++; if (dutData() !== data_t'(0)) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", dutData()); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_midrun();
        drive(0, 32'h0, 32'h0, 1, 5'd5, 32'h1234, 0);
        tick();
        drive(1, 32'h005280B3, 32'h40, 0, 5'd0, 32'h0, 0);   // add x1,x5,x5
        tick();
        checks++; if (bus.ex_a !== 32'h1234) begin errors++; $display("[TB] FAIL pre_reset_a got=%h exp=%h", bus.ex_a, 32'h1234); end
        #1 rst = 1'b1;
        #1;
        checks++; if (dutCtrl() !== ctrl_t'(0)) begin errors++; $display("[TB] FAIL midreset_ctrl got=%h exp=0", dutCtrl()); end
        checks++; if (dutData() !== data_t'(0)) begin errors++; $display("[TB] FAIL midreset_data got=%h exp=0", dutData()); end
        rst = 1'b0;
        modelReset();
        tick();
        checks++; if (bus.ex_a !== 32'h0 || bus.ex_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL post_reset_x5 got a=%h v=%b exp a=0 v=1", bus.ex_a, bus.ex_valid);
        end
    endtask

    task automatic test_bypass();
        drive(1, 32'h003180B3, 32'h80, 1, 5'd3, 32'hDEADBEEF, 0);   // add x1,x3,x3
        tick();
        checks++; if (bus.ex_a !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bypass_a got=%h exp=deadbeef", bus.ex_a); end
        checks++; if (bus.ex_b !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bypass_b got=%h exp=deadbeef", bus.ex_b); end
        drive(1, 32'h000000B3, 32'h84, 1, 5'd0, 32'hDEADBEEF, 0);   // add x1,x0,x0
        tick();
        checks++; if (bus.ex_a !== 32'h0) begin errors++; $display("[TB] FAIL bypass_x0 got=%h exp=0", bus.ex_a); end
        drive(1, 32'h003180B3, 32'h88, 0, 5'd0, 32'h0, 0);
        tick();
        checks++; if (bus.ex_a !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL regfile_x3 got=%h exp=deadbeef", bus.ex_a); end
    endtask

    task automatic test_load_use();
        drive(1, 32'h0040A103, 32'h100, 0, 5'd0, 32'h0, 0);   // lw x2,4(x1)
        tick();
        drive(1, 32'h004101B3, 32'h104, 0, 5'd0, 32'h0, 0);   // add x3,x2,x4
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL loaduse_stall got=%b exp=1", bus.stall); end
        tick();
        checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_bubble got=%b exp=0", bus.ex_valid); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL loaduse_one_cycle got=%b exp=0", bus.stall); end
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rs1 !== 5'd2 || bus.ex_rd !== 5'd3) begin
            errors++; $display("[TB] FAIL loaduse_issue got v=%b rs1=%0d rd=%0d exp v=1 rs1=2 rd=3", bus.ex_valid, bus.ex_rs1, bus.ex_rd);
        end
        drive(1, 32'h0040A103, 32'h108, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, 32'h002201B3, 32'h10C, 0, 5'd0, 32'h0, 0);   // add x3,x4,x2
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL loaduse_rs2 got=%b exp=1", bus.stall); end
        drive(1, 32'h000102B7, 32'h10C, 0, 5'd0, 32'h0, 0);   // lui x5 with rs1 field = 2
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL lui_no_rs1 got=%b exp=0", bus.stall); end
        tick();
        drive(1, 32'h0040A003, 32'h110, 0, 5'd0, 32'h0, 0);   // lw x0,4(x1)
        tick();
        drive(1, 32'h004001B3, 32'h114, 0, 5'd0, 32'h0, 0);   // add x3,x0,x4
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL load_x0 got=%b exp=0", bus.stall); end
        tick();
    endtask

    task automatic test_immediates();
        drive(1, 32'hFE000EE3, 32'h200, 0, 5'd0, 32'h0, 0);   // beq -4
        tick();
        checks++; if (bus.ex_imm !== 32'hFFFFFFFC || bus.ex_branch !== 1'b1) begin
            errors++; $display("[TB] FAIL imm_b got imm=%h br=%b exp imm=fffffffc br=1", bus.ex_imm, bus.ex_branch);
        end
        drive(1, 32'h001000EF, 32'h204, 0, 5'd0, 32'h0, 0);   // jal x1,+2048
        tick();
        checks++; if (bus.ex_imm !== 32'h00000800 || bus.ex_wb_sel !== 2'd2 || bus.ex_jump !== 1'b1) begin
            errors++; $display("[TB] FAIL imm_j got imm=%h wb=%0d j=%b exp imm=00000800 wb=2 j=1", bus.ex_imm, bus.ex_wb_sel, bus.ex_jump);
        end
    endtask

    task automatic test_flush_vs_stall();
        drive(1, 32'h0040A103, 32'h300, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, 32'h004101B3, 32'h304, 0, 5'd0, 32'h0, 1);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall got=%b exp=0", bus.stall); end
        tick();
        checks++; if (dutCtrl() !== ctrl_t'(0)) begin errors++; $display("[TB] FAIL flush_bubble got=%h exp=0", dutCtrl()); end
        drive(0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        tick();
    endtask

    task automatic test_illegal();
        drive(1, 32'h0000007F, 32'h400, 0, 5'd0, 32'h0, 0);
        tick();
        checks++; if (bus.ex_valid !== 1'b1 || bus.ex_illegal !== 1'b1 || bus.ex_regwrite !== 1'b0 || bus.ex_memwrite !== 1'b0) begin
            errors++; $display("[TB] FAIL illegal got v=%b ill=%b rw=%b mw=%b exp 1 1 0 0",
                               bus.ex_valid, bus.ex_illegal, bus.ex_regwrite, bus.ex_memwrite);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [12] = '{7'h33, 7'h13, 7'h03, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        logic        held;
        logic        expStall;
        logic [31:0] ir;
        data_t       gotD, expD;
        held = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!held) begin
                ir = $urandom;
                ir[6:0]   = ops[$urandom_range(0, 11)];
                ir[11:7]  = 5'($urandom_range(0, 3));
                ir[19:15] = 5'($urandom_range(0, 3));
                ir[24:20] = 5'($urandom_range(0, 3));
                bus.if_valid = ($urandom_range(0, 9) != 0);
                bus.if_ir    = ir;
                bus.if_pc    = $urandom & 32'hFFFF_FFFC;
            end
            bus.wb_we    = 1'($urandom_range(0, 1));
            bus.wb_rd    = 5'($urandom_range(0, 3));
            bus.wb_data  = $urandom;
            bus.ex_flush = ($urandom_range(0, 9) == 0);
            #1;
            expStall = modelStall();
            checks++; if (bus.stall !== expStall) begin errors++; $display("[TB] FAIL rand_stall n=%0d got=%b exp=%b", n, bus.stall, expStall); end
            held = expStall;
            tick();
            checks++; if (dutCtrl() !== mCtrl) begin errors++; $display("[TB] FAIL rand_ctrl n=%0d got=%h exp=%h", n, dutCtrl(), mCtrl); end
            if (mCtrl.valid) begin
                gotD = dutData();
                expD = mData;
                if (mCtrl.illegal) begin gotD.imm = '0; expD.imm = '0; end
                checks++; if (gotD !== expD) begin errors++; $display("[TB] FAIL rand_data n=%0d got=%h exp=%h", n, gotD, expD); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_midrun();
        test_bypass();
        test_load_use();
        test_immediates();
        test_flush_vs_stall();
        test_illegal();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
